// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: tag flag positions, 2-bit counter
// encodings and the saturating counter update.
package bp_pkg;

  localparam int IDX_W = 3;
  localparam int TAG_W = 30;

  // Bit positions inside the BranchFlags / UpdFlags tag
  localparam int FLAG_HIT = 1;
  localparam int FLAG_PT  = 0;

  // 2-bit counter states: strongly/weakly not-taken, weakly/strongly taken
  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  // Move the counter one step toward the observed outcome, clamping at the ends
  function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end else begin
      nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_cam_match.sv
// Fully-associative tag match: reports whether any valid entry holds the key
// and, if several do, the lowest matching index.
module bp_cam_match
  import bp_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int IDX_W_P = 3
) (
  input  logic [ENTRIES-1:0]            valid_i,
  input  logic [ENTRIES-1:0][TAG_W-1:0] tag_i,
  input  logic [TAG_W-1:0]              key_i,
  output logic                          hit_o,
  output logic [IDX_W_P-1:0]            idx_o
);

  // Scan from the top down so the lowest matching index is the last one written
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_i[i] && (tag_i[i] == key_i)) begin
        hit_o = 1'b1;
        idx_o = IDX_W_P'(i);
      end
    end
  end

endmodule

// File: rtl/bht_2bit_btb.sv
// Fully-associative BTB with a 2-bit saturating direction counter per entry.
// Lookup is combinational on PC_In; updates from EX resolution are applied at
// the clock edge. Optional performance counters are enabled with the macro
// BHT_PERF_CNT_EN (adds PerfBranches / PerfMispred outputs).
module bht_2bit_btb #(
  parameter int         ENTRIES  = 8,
  parameter int         IDX_W    = 3,
  parameter logic [1:0] INIT_CTR = 2'b10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       PC_In,
  output logic              PredTaken,
  output logic [31:0]       PredTarget,
  output logic [1:0]        BranchFlags,
  output logic [IDX_W-1:0]  BranchIndex,
  input  logic              UpdEn,
  input  logic [1:0]        UpdFlags,
  input  logic [IDX_W-1:0]  UpdIndex,
  input  logic [31:0]       UpdPC,
  input  logic              UpdTaken,
  input  logic [31:0]       UpdTarget
`ifdef BHT_PERF_CNT_EN
  ,
  output logic [31:0]       PerfBranches,
  output logic [31:0]       PerfMispred
`endif
);

  import bp_pkg::*;

  // Table state
  logic [ENTRIES-1:0]            valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q,   tag_d;
  logic [ENTRIES-1:0][31:0]      tgt_q,   tgt_d;
  logic [ENTRIES-1:0][1:0]       ctr_q,   ctr_d;
  logic [IDX_W-1:0]              vptr_q,  vptr_d;

  // Lookup port
  logic             lk_hit;
  logic [IDX_W-1:0] lk_idx;

  // Update port
  logic             rs_hit;
  logic [IDX_W-1:0] rs_idx;
  logic             trusted_hit;
  logic             upd_hit;
  logic [IDX_W-1:0] upd_idx;

  // Address bits below the word tag (and the predicted-taken flag bit when
  // the perf counters are compiled out) carry no information here.
  logic unused_bits;
  assign unused_bits = ^{PC_In[1:0], UpdPC[1:0], UpdFlags[FLAG_PT]};

  bp_cam_match #(
    .ENTRIES (ENTRIES),
    .IDX_W_P (IDX_W)
  ) u_cam_lookup (
    .valid_i (valid_q),
    .tag_i   (tag_q),
    .key_i   (PC_In[31:2]),
    .hit_o   (lk_hit),
    .idx_o   (lk_idx)
  );

  // Second matcher re-searches for the resolving PC so an entry allocated by an
  // earlier in-flight update is found instead of being allocated twice.
  bp_cam_match #(
    .ENTRIES (ENTRIES),
    .IDX_W_P (IDX_W)
  ) u_cam_update (
    .valid_i (valid_q),
    .tag_i   (tag_q),
    .key_i   (UpdPC[31:2]),
    .hit_o   (rs_hit),
    .idx_o   (rs_idx)
  );

  // The carried tag is trusted only if its entry still holds this branch;
  // otherwise the entry was replaced in flight and the re-search decides.
  assign trusted_hit = UpdFlags[FLAG_HIT] && valid_q[UpdIndex] &&
                       (tag_q[UpdIndex] == UpdPC[31:2]);
  assign upd_hit     = trusted_hit || rs_hit;
  assign upd_idx     = trusted_hit ? UpdIndex : rs_idx;

  // Drive the prediction from the pre-update table; all zero on a miss
  always_comb begin
    PredTaken   = 1'b0;
    PredTarget  = '0;
    BranchFlags = 2'b00;
    BranchIndex = '0;
    if (lk_hit) begin
      PredTaken             = ctr_q[lk_idx][1];
      PredTarget            = tgt_q[lk_idx];
      BranchFlags[FLAG_HIT] = 1'b1;
      BranchFlags[FLAG_PT]  = ctr_q[lk_idx][1];
      BranchIndex           = lk_idx;
    end
  end

  // Next table state: train a hitting entry, or allocate round-robin on a taken miss
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    vptr_d  = vptr_q;
    if (UpdEn) begin
      if (upd_hit) begin
        ctr_d[upd_idx] = sat_ctr(ctr_q[upd_idx], UpdTaken);
        if (UpdTaken) begin
          tgt_d[upd_idx] = UpdTarget;
        end
      end else if (UpdTaken) begin
        valid_d[vptr_q] = 1'b1;
        tag_d[vptr_q]   = UpdPC[31:2];
        tgt_d[vptr_q]   = UpdTarget;
        ctr_d[vptr_q]   = INIT_CTR;
        vptr_d          = (vptr_q == IDX_W'(ENTRIES - 1)) ? '0 : vptr_q + IDX_W'(1);
      end
    end
  end

  // Table and victim-pointer registers; reset clears to an empty table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
      vptr_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= INIT_CTR;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
      vptr_q  <= vptr_d;
    end
  end

`ifdef BHT_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_br_d;
  logic [31:0] perf_mp_q, perf_mp_d;
  logic        pred_taken_upd;
  logic        mispred;

  // A taken prediction is wrong if the direction differs or the target moved
  assign pred_taken_upd = (UpdFlags == 2'b11);
  assign mispred        = (pred_taken_upd != UpdTaken) ||
                          (pred_taken_upd && trusted_hit && (UpdTarget != tgt_q[UpdIndex]));

  // Count resolved branches and mispredictions, wrapping naturally
  always_comb begin
    perf_br_d = perf_br_q;
    perf_mp_d = perf_mp_q;
    if (UpdEn) begin
      perf_br_d = perf_br_q + 32'd1;
      if (mispred) begin
        perf_mp_d = perf_mp_q + 32'd1;
      end
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
    end
  end

  assign PerfBranches = perf_br_q;
  assign PerfMispred  = perf_mp_q;
`endif

endmodule

// File: tb/tb_bht_2bit_btb.sv
module tb_bht_2bit_btb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC_In;
  logic        PredTaken;
  logic [31:0] PredTarget;
  logic [1:0]  BranchFlags;
  logic [2:0]  BranchIndex;
  logic        UpdEn;
  logic [1:0]  UpdFlags;
  logic [2:0]  UpdIndex;
  logic [31:0] UpdPC;
  logic        UpdTaken;
  logic [31:0] UpdTarget;
`ifdef BHT_PERF_CNT_EN
  logic [31:0] PerfBranches;
  logic [31:0] PerfMispred;
`endif

  always #5 clk = ~clk;

  bht_2bit_btb #(.ENTRIES(8), .IDX_W(3), .INIT_CTR(2'b10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PC_In       (PC_In),
    .PredTaken   (PredTaken),
    .PredTarget  (PredTarget),
    .BranchFlags (BranchFlags),
    .BranchIndex (BranchIndex),
    .UpdEn       (UpdEn),
    .UpdFlags    (UpdFlags),
    .UpdIndex    (UpdIndex),
    .UpdPC       (UpdPC),
    .UpdTaken    (UpdTaken),
    .UpdTarget   (UpdTarget)
`ifdef BHT_PERF_CNT_EN
    ,
    .PerfBranches(PerfBranches),
    .PerfMispred (PerfMispred)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] obs();
    return {26'd0, PredTaken, PredTarget, BranchFlags, BranchIndex};
  endfunction

  function automatic logic [63:0] pack(input logic tk, input logic [31:0] tg,
                                       input logic [1:0] fl, input logic [2:0] ix);
    return {26'd0, tk, tg, fl, ix};
  endfunction

  task automatic drive(input logic en, input logic [1:0] fl, input logic [2:0] ix,
                       input logic [31:0] upc, input logic tk, input logic [31:0] utg,
                       input logic [31:0] pc);
    UpdEn = en; UpdFlags = fl; UpdIndex = ix; UpdPC = upc;
    UpdTaken = tk; UpdTarget = utg; PC_In = pc;
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_val [8];
  int unsigned m_tag [8];
  logic [31:0] m_tgt [8];
  int          m_ctr [8];
  int          m_vptr;
  int unsigned m_br, m_mp;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 2;
    end
    m_vptr = 0; m_br = 0; m_mp = 0;
  endtask

  function automatic int model_find(input logic [31:0] pc);
    for (int i = 0; i < 8; i++)
      if (m_val[i] && m_tag[i] == (pc >> 2)) return i;
    return -1;
  endfunction

  function automatic logic [63:0] model_lookup(input logic [31:0] pc);
    int e = model_find(pc);
    logic pt;
    if (e < 0) return 64'd0;
    pt = (m_ctr[e] >= 2);
    return pack(pt, m_tgt[e], {1'b1, pt}, 3'(e));
  endfunction

  task automatic model_update(input logic en, input logic [1:0] fl, input logic [2:0] ix,
                              input logic [31:0] upc, input logic tk, input logic [31:0] utg);
    int e;
    bit trusted, pt;
    if (!en) return;
    e = model_find(upc);
    trusted = fl[1] && (e == int'(ix));
    pt = (fl == 2'b11);
    m_br++;
    if ((pt != tk) || (pt && trusted && utg != m_tgt[e])) m_mp++;
    if (e >= 0) begin
      m_ctr[e] = tk ? ((m_ctr[e] + 1 > 3) ? 3 : m_ctr[e] + 1)
                    : ((m_ctr[e] - 1 < 0) ? 0 : m_ctr[e] - 1);
      if (tk) m_tgt[e] = utg;
    end else if (tk) begin
      m_val[m_vptr] = 1; m_tag[m_vptr] = upc >> 2; m_tgt[m_vptr] = utg; m_ctr[m_vptr] = 2;
      m_vptr = (m_vptr + 1) % 8;
    end
  endtask

  // Reset with an update pending; it must be discarded
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 2'b00, 3'd0, 32'h100, 1'b1, 32'h44, 32'h100);
    #2;
    check("reset_outputs", obs(), 64'd0);
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 2'b00, 3'd0, 32'h0, 1'b0, 32'h0, 32'h100);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic upd_cycle(input logic [1:0] fl, input logic [2:0] ix, input logic [31:0] upc,
                           input logic tk, input logic [31:0] utg);
    @(negedge clk);
    drive(1'b1, fl, ix, upc, tk, utg, 32'h0);
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic [63:0] exp);
    @(negedge clk);
    drive(1'b0, 2'b00, 3'd0, 32'h0, 1'b0, 32'h0, pc);
    #2;
    check(name, obs(), exp);
  endtask

  typedef struct {
    logic en; logic [1:0] fl; logic [2:0] ix; logic [31:0] upc; logic tk; logic [31:0] utg;
    logic [31:0] pc; logic [1:0] e_fl; logic [2:0] e_ix; logic [31:0] e_tg; logic e_tk;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic [1:0] fl, input logic tk,
                              input logic [31:0] utg, input logic [1:0] e_fl,
                              input logic [31:0] e_tg);
    vec_t v;
    v.en = en; v.fl = fl; v.ix = 3'd0; v.upc = 32'h100; v.tk = tk; v.utg = utg;
    v.pc = 32'h100; v.e_fl = e_fl; v.e_ix = 3'd0; v.e_tg = e_tg; v.e_tk = e_fl[0];
    return v;
  endfunction

  vec_t vt [13];
  logic [31:0] pool [12];
  logic        r_en, r_tk;
  logic [1:0]  r_fl;
  logic [2:0]  r_ix;
  logic [31:0] r_upc, r_utg, r_pc;
  logic [63:0] r_exp;

  initial begin
    drive(1'b0, 2'b00, 3'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;

    // Allocate, decay to 0 and hold, then climb to 3 and hold
    vt[0]  = mk(0, 2'b00, 0, 32'h00, 2'b00, 32'h00);
    vt[1]  = mk(1, 2'b00, 1, 32'h40, 2'b00, 32'h00);
    vt[2]  = mk(0, 2'b00, 0, 32'h00, 2'b11, 32'h40);
    vt[3]  = mk(1, 2'b11, 0, 32'h00, 2'b11, 32'h40);
    vt[4]  = mk(1, 2'b11, 0, 32'h00, 2'b10, 32'h40);
    vt[5]  = mk(1, 2'b10, 0, 32'h00, 2'b10, 32'h40);
    vt[6]  = mk(0, 2'b00, 0, 32'h00, 2'b10, 32'h40);
    vt[7]  = mk(1, 2'b10, 1, 32'h40, 2'b10, 32'h40);
    vt[8]  = mk(1, 2'b10, 1, 32'h40, 2'b10, 32'h40);
    vt[9]  = mk(1, 2'b11, 1, 32'h40, 2'b11, 32'h40);
    vt[10] = mk(1, 2'b11, 1, 32'h40, 2'b11, 32'h40);
    vt[11] = mk(1, 2'b11, 0, 32'h00, 2'b11, 32'h40);
    vt[12] = mk(0, 2'b00, 0, 32'h00, 2'b11, 32'h40);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vt[i].en, vt[i].fl, vt[i].ix, vt[i].upc, vt[i].tk, vt[i].utg, vt[i].pc);
      #2;
      check($sformatf("table_step%0d", i), obs(),
            pack(vt[i].e_tk, vt[i].e_tg, vt[i].e_fl, vt[i].e_ix));
    end

    // Wrap: nine allocations, the ninth replaces index 0
    do_reset();
    for (int k = 0; k < 9; k++)
      upd_cycle(2'b00, 3'd0, 32'h200 + 32'(4 * k), 1'b1, 32'h1000 + 32'(16 * k));
    look("wrap_miss_100", 32'h100, 64'd0);
    look("wrap_ninth_idx0", 32'h220, pack(1'b1, 32'h1080, 2'b11, 3'd0));
    look("wrap_first_evicted", 32'h200, 64'd0);
    look("wrap_second_idx1", 32'h204, pack(1'b1, 32'h1010, 2'b11, 3'd1));

    // Duplicate guard: two in-flight misses for the same PC
    upd_cycle(2'b00, 3'd0, 32'h300, 1'b1, 32'h80);
    upd_cycle(2'b00, 3'd0, 32'h300, 1'b1, 32'h80);
    look("dup_single_entry", 32'h300, pack(1'b1, 32'h80, 2'b11, 3'd1));
    upd_cycle(2'b11, 3'd1, 32'h300, 1'b0, 32'h0);
    look("dup_ctr_was_3", 32'h300, pack(1'b1, 32'h80, 2'b11, 3'd1));
    upd_cycle(2'b00, 3'd0, 32'h400, 1'b1, 32'h90);
    look("dup_vptr_advanced_once", 32'h400, pack(1'b1, 32'h90, 2'b11, 3'd2));

    // Same-cycle allocate and lookup
    @(negedge clk);
    drive(1'b1, 2'b00, 3'd0, 32'h500, 1'b1, 32'hA0, 32'h500);
    #2;
    check("same_cycle_miss", obs(), 64'd0);
    look("same_cycle_next_hit", 32'h500, pack(1'b1, 32'hA0, 2'b11, 3'd3));

`ifdef BHT_PERF_CNT_EN
    do_reset();
    #1;
    check("perf_reset_br", 64'(PerfBranches), 64'd0);
    upd_cycle(2'b11, 3'd0, 32'h600, 1'b0, 32'h0);
    look("perf_miss_lookup", 32'h600, 64'd0);
    check("perf_mispred_1", 64'(PerfMispred), 64'd1);
    check("perf_branches_1", 64'(PerfBranches), 64'd1);
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 12; i++) pool[i] = 32'h1000 + 32'(4 * i);
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      r_pc  = pool[$urandom_range(0, 11)];
      r_upc = pool[$urandom_range(0, 11)];
      r_en  = ($urandom_range(0, 3) != 0);
      r_tk  = 1'($urandom_range(0, 1));
      r_utg = ($urandom_range(0, 1) != 0) ? 32'h2000 : 32'h2004;
      if ($urandom_range(0, 3) == 0) begin
        r_fl = 2'($urandom_range(0, 3));
        r_ix = 3'($urandom_range(0, 7));
      end else begin
        r_exp = model_lookup(r_upc);
        r_fl = r_exp[4:3];
        r_ix = r_exp[2:0];
      end
      drive(r_en, r_fl, r_ix, r_upc, r_tk, r_utg, r_pc);
      #2;
      check($sformatf("rand_lookup_c%0d", c), obs(), model_lookup(r_pc));
`ifdef BHT_PERF_CNT_EN
      check($sformatf("rand_perf_c%0d", c), {PerfBranches, PerfMispred}, {m_br, m_mp});
`endif
      model_update(r_en, r_fl, r_ix, r_upc, r_tk, r_utg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
